pipe_ctrl: RTL

//  Central pipeline controller for the 5-stage CPU core. Merges per-stage stall requests into the
//  6-bit stall vector consumed by the PC register and IF/ID/EX/MEM/WB pipeline registers.

---
 rtl/pipe_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, sequences exception/ERET
// redirects (freeze -> flush -> refill), and keeps a stall watchdog plus perf counters.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          WDOG_LIMIT = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if_i,
    input  logic             stallreq_id_i,
    input  logic             stallreq_ex_i,
    input  logic             stallreq_mem_i,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic             wdog_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [1:0]  ST_RUN    = 2'd0;
    localparam logic [1:0]  ST_FLUSH  = 2'd1;
    localparam logic [1:0]  ST_REFILL = 2'd2;
    localparam logic [31:0] ERET_CODE = 32'h0000000e;

    localparam int          WW        = $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] WDOG_MAX  = WW'(WDOG_LIMIT);
    localparam logic [WW-1:0] WDOG_TRIP = WW'(WDOG_LIMIT - 1);

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [5:0]    req_stall;
    logic          detect;
    logic          stalled;
    logic [WW-1:0] wdog_cnt;

    // Deepest requesting stage wins: it and everything upstream of it hold.
    always_comb begin
        req_stall = 6'b000000;
        if (stallreq_mem_i)
            req_stall = 6'b011111;
        else if (stallreq_ex_i)
            req_stall = 6'b001111;
        else if (stallreq_id_i)
            req_stall = 6'b000111;
        else if (stallreq_if_i)
            req_stall = 6'b000011;
    end

    assign detect = (state == ST_RUN) && (excepttype_i != 32'h0);

    always_comb begin
        stall_o = 6'b000000;
        if (!rst) begin
            if (detect)
                stall_o = 6'b111111;
            else if (state != ST_FLUSH)
                stall_o = req_stall;
        end
    end

    assign stalled = (stall_o != 6'b000000);

    always_comb begin
        state_next = ST_RUN;
        case (state)
            ST_RUN:    state_next = detect ? ST_FLUSH : ST_RUN;
            ST_FLUSH:  state_next = ST_REFILL;
            ST_REFILL: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    // The redirect target is captured straight into new_pc_o on the detect edge,
    // so later EPC changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            flush_o     <= 1'b0;
            new_pc_o    <= 32'h0;
            flush_cnt_o <= '0;
        end else begin
            state   <= state_next;
            flush_o <= detect;
            if (detect) begin
                new_pc_o    <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            wdog_cnt    <= '0;
            wdog_o      <= 1'b0;
        end else if (stalled) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (wdog_cnt != WDOG_MAX)
                wdog_cnt <= wdog_cnt + WW'(1);
            if (wdog_cnt >= WDOG_TRIP)
                wdog_o <= 1'b1;
        end else begin
            wdog_cnt <= '0;
        end
    end

endmodule
